// File: rtl/latch_write_sequencer_if.sv
// -----------------------------------------------------------------------------
// latch_write_sequencer_if
//
// Upstream write handshake for latch_write_sequencer.
//   in_data  : word to write (WIDTH bits), driven by the master
//   in_valid : in_data is valid, driven by the master
//   in_ready : sequencer can accept a word this cycle, driven by the slave
// A word is transferred on a rising edge where in_valid and in_ready are both 1.
// The master must hold in_data/in_valid until the word is accepted.
// -----------------------------------------------------------------------------
interface latch_write_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/latch_write_sequencer.sv
// -----------------------------------------------------------------------------
// latch_write_sequencer
//
// Drives a bank of WIDTH transparent D latches. Each word accepted over the
// valid/ready handshake is presented on D, an enable pulse is generated on E
// with programmable setup / pulse / hold margins, and the latch Q outputs are
// read back at the end of the hold window and compared with the written word.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous, active-high reset
//   up       : write handshake (in_data / in_valid / in_ready), slave side
//   D        : data to the latch bank D inputs (registered)
//   E        : latch enable, transparent when 1 (registered)
//   Q        : latch bank Q readback
//   busy     : a write sequence is in progress
//   done     : one-cycle pulse, write sequence finished (registered)
//   err      : valid with done, readback differed from the written word
//   err_cnt  : saturating count of mismatches since reset (registered)
//
// Timing for an accept at edge N (S/P/H = SETUP/PULSE/HOLD_CYC):
//   E is 1 after edges N+S .. N+S+P-1, done is 1 after edge N+S+P+H,
//   in_ready is 1 again after edge N+S+P+H+1.
// -----------------------------------------------------------------------------
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int ERRCNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    latch_write_sequencer_if.slave  up,
    output logic [WIDTH-1:0]        D,
    output logic                    E,
    input  logic [WIDTH-1:0]        Q,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ERRCNT_W-1:0]     err_cnt
);

    // Dwell counter is wide enough for the longest of the three windows.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter is loaded with (dwell - 1) on state entry and the state is
    // left on the edge where it reads zero, giving exactly `dwell` cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    word_q;
    logic [WIDTH-1:0]    d_q;
    logic                e_q;
    logic                done_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] err_cnt_q;

    logic [ERRCNT_W-1:0] err_cnt_d;
    logic                mismatch_d;

    // Saturating increment of the error counter and the readback compare.
    always_comb begin
        err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERRCNT_W'(1);
        mismatch_d = (Q != word_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            d_q       <= '0;
            e_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            // done/err are single-cycle pulses, only set when entering CHECK.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // D only ever changes here, while E is known to be 0.
                    if (up.in_valid) begin
                        word_q  <= up.in_data;
                        d_q     <= up.in_data;
                        cnt_q   <= SETUP_LD;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= PULSE_LD;
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= HOLD_LD;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    // Q is sampled on the edge that closes the hold window.
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        err_q   <= mismatch_d;
                        if (mismatch_d) begin
                            err_cnt_q <= err_cnt_d;
                        end
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_CHECK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    e_q     <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is also gated by rst so nothing is offered while in reset.
    assign up.in_ready = (state_q == S_IDLE) && !rst;
    assign busy        = (state_q != S_IDLE);
    assign D           = d_q;
    assign E           = e_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_latch_write_sequencer
//
// Three sequencer instances share one clock:
//   0 : default parameters
//   1 : ERRCNT_W=2 (saturation)
//   2 : SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2
// Each drives a behavioural transparent latch bank whose Q can be forced to
// 0 (stuck fault). Expected waveforms come from the accept edge plus the
// instance's S/P/H windows; expected err from what the latch model would hold.
// -----------------------------------------------------------------------------
module tb_latch_write_sequencer;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Per-instance parameters as seen by the reference model.
    int S_C  [3] = '{1, 1, 3};
    int P_C  [3] = '{2, 2, 1};
    int H_C  [3] = '{1, 1, 2};
    int MAXC [3] = '{255, 3, 255};

    logic       rst_w      [3];
    logic [7:0] in_data_w  [3];
    logic       in_valid_w [3];
    logic       rdy_w      [3];
    logic [7:0] D_w        [3];
    logic       E_w        [3];
    logic [7:0] Q_w        [3];
    logic       busy_w     [3];
    logic       done_w     [3];
    logic       err_w      [3];
    logic [7:0] ec_w       [3];
    logic       stuck_w    [3];

    // Reference-model state.
    int         exp_cnt   [3];
    int         last_acc  [3];
    bit         prev_keep [3];
    logic [7:0] last_d    [3];

    logic [7:0] ec0;
    logic [1:0] ec1;
    logic [7:0] ec2;

    latch_write_sequencer_if #(.WIDTH(8)) bus0 ();
    latch_write_sequencer_if #(.WIDTH(8)) bus1 ();
    latch_write_sequencer_if #(.WIDTH(8)) bus2 ();

    assign bus0.in_data  = in_data_w[0];
    assign bus0.in_valid = in_valid_w[0];
    assign rdy_w[0]      = bus0.in_ready;
    assign bus1.in_data  = in_data_w[1];
    assign bus1.in_valid = in_valid_w[1];
    assign rdy_w[1]      = bus1.in_ready;
    assign bus2.in_data  = in_data_w[2];
    assign bus2.in_valid = in_valid_w[2];
    assign rdy_w[2]      = bus2.in_ready;
    assign ec_w[0]       = ec0;
    assign ec_w[1]       = {6'b0, ec1};
    assign ec_w[2]       = ec2;

    latch_write_sequencer #(.WIDTH(8)) u0 (
        .clk(clk), .rst(rst_w[0]), .up(bus0.slave),
        .D(D_w[0]), .E(E_w[0]), .Q(Q_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .err_cnt(ec0)
    );

    latch_write_sequencer #(.WIDTH(8), .ERRCNT_W(2)) u1 (
        .clk(clk), .rst(rst_w[1]), .up(bus1.slave),
        .D(D_w[1]), .E(E_w[1]), .Q(Q_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .err_cnt(ec1)
    );

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u2 (
        .clk(clk), .rst(rst_w[2]), .up(bus2.slave),
        .D(D_w[2]), .E(E_w[2]), .Q(Q_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]), .err_cnt(ec2)
    );

    // Behavioural transparent latch banks with an optional stuck-at-0 fault.
    for (genvar gi = 0; gi < 3; gi++) begin : g_latch
        logic [7:0] lat;
        always_latch begin
            if (E_w[gi]) lat <= D_w[gi];
        end
        assign Q_w[gi] = stuck_w[gi] ? 8'h00 : lat;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One complete write on instance k. Called right after a falling edge.
    task automatic do_write(input int k, input logic [7:0] data, input bit keep);
        int         s, p, h, tot, acc;
        logic [7:0] ref_q;
        logic       exp_err;
        bit         ok;
        s   = S_C[k];
        p   = P_C[k];
        h   = H_C[k];
        tot = s + p + h;
        in_data_w[k]  = data;
        in_valid_w[k] = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (rdy_w[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_wait", 32'(ok), 32'd1);
        if (!ok) begin
            in_valid_w[k] = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (prev_keep[k]) check("accept_spacing", 32'(acc - last_acc[k]), 32'(tot + 2));
        last_acc[k]  = acc;
        prev_keep[k] = keep;

        // What an ideal (or stuck) latch would return after the pulse.
        ref_q   = stuck_w[k] ? 8'h00 : data;
        exp_err = (ref_q != data);
        if (exp_err && exp_cnt[k] < MAXC[k]) exp_cnt[k]++;

        for (int t = 0; t <= tot + 1; t++) begin
            @(negedge clk);
            if (t == 0 && !keep) in_valid_w[k] = 1'b0;
            check("D", 32'(D_w[k]), 32'(data));
            check("E", 32'(E_w[k]), 32'((t >= s) && (t < s + p)));
            check("done", 32'(done_w[k]), 32'(t == tot));
            check("busy", 32'(busy_w[k]), 32'(t <= tot));
            check("in_ready", 32'(rdy_w[k]), 32'(t == tot + 1));
            if (t == tot) check("err", 32'(err_w[k]), 32'(exp_err));
            if (t == tot + 1) check("err_cnt", 32'(ec_w[k]), 32'(exp_cnt[k]));
        end
        last_d[k] = data;
        $display("write k=%0d data=%02h keep=%0d stuck=%0d exp_err=%0d err_cnt=%0d",
                 k, data, keep, stuck_w[k], exp_err, exp_cnt[k]);
    endtask

    task automatic idle_gap(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_D_hold", 32'(D_w[k]), 32'(last_d[k]));
            check("idle_E", 32'(E_w[k]), 32'd0);
            check("idle_done", 32'(done_w[k]), 32'd0);
        end
    endtask

    initial begin
        int         k, kn, n;
        logic [7:0] dat;
        bit         keep;

        for (int i = 0; i < 3; i++) begin
            rst_w[i]      = 1'b1;
            in_valid_w[i] = 1'b1;
            in_data_w[i]  = 8'($urandom);
            stuck_w[i]    = 1'b0;
            exp_cnt[i]    = 0;
            last_acc[i]   = 0;
            prev_keep[i]  = 1'b0;
            last_d[i]     = 8'h00;
        end

        // Reset held 3 cycles with in_valid asserted.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("rst_D", 32'(D_w[i]), 32'd0);
                check("rst_E", 32'(E_w[i]), 32'd0);
                check("rst_in_ready", 32'(rdy_w[i]), 32'd0);
                check("rst_done", 32'(done_w[i]), 32'd0);
                check("rst_err_cnt", 32'(ec_w[i]), 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            rst_w[i]      = 1'b0;
            in_valid_w[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) check("post_rst_in_ready", 32'(rdy_w[i]), 32'd1);
        $display("reset sequence done");
        idle_gap(0, 1);

        // Single A5 write, then the next accept exactly 6 cycles later.
        do_write(0, 8'hA5, 1'b1);
        do_write(0, 8'($urandom), 1'b0);
        idle_gap(0, 2);

        // Back-to-back writes with in_valid held high.
        do_write(0, 8'h00, 1'b1);
        do_write(0, 8'hFF, 1'b1);
        do_write(0, 8'h3C, 1'b0);
        idle_gap(0, 1);

        // Stuck latch on the default instance.
        stuck_w[0] = 1'b1;
        do_write(0, 8'hFF, 1'b0);
        stuck_w[0] = 1'b0;
        idle_gap(0, 1);

        // Saturation of a 2-bit error counter.
        stuck_w[1] = 1'b1;
        do_write(1, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) do_write(1, 8'($urandom) | 8'h01, 1'b0);
        stuck_w[1] = 1'b0;
        idle_gap(1, 1);

        // Reset while E is high.
        in_data_w[0]  = 8'hC3;
        in_valid_w[0] = 1'b1;
        n = 0;
        while (!rdy_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid_w[0] = 1'b0;
        @(negedge clk);
        check("midrst_E_before", 32'(E_w[0]), 32'd1);
        rst_w[0] = 1'b1;
        @(negedge clk);
        check("midrst_E", 32'(E_w[0]), 32'd0);
        check("midrst_D", 32'(D_w[0]), 32'd0);
        check("midrst_done", 32'(done_w[0]), 32'd0);
        check("midrst_in_ready", 32'(rdy_w[0]), 32'd0);
        rst_w[0] = 1'b0;
        exp_cnt[0]   = 0;
        last_d[0]    = 8'h00;
        prev_keep[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done_w[0]), 32'd0);
            check("midrst_idle", 32'(rdy_w[0]), 32'd1);
        end
        check("midrst_err_cnt", 32'(ec_w[0]), 32'd0);
        $display("reset during PULSE done");

        // Non-default timing instance.
        do_write(2, 8'h5A, 1'b1);
        do_write(2, 8'($urandom), 1'b0);
        idle_gap(2, 1);

        // Randomised traffic across all instances.
        k = int'($urandom_range(0, 2));
        for (int it = 0; it < 24; it++) begin
            kn   = int'($urandom_range(0, 2));
            keep = (kn == k) && ($urandom_range(0, 1) == 1);
            dat  = 8'($urandom);
            stuck_w[k] = ($urandom_range(0, 3) == 0);
            do_write(k, dat, keep);
            stuck_w[k] = 1'b0;
            if (!keep) idle_gap(k, int'($urandom_range(0, 3)));
            k = kn;
        end
        in_valid_w[k] = 1'b0;
        idle_gap(k, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
